multicycle_control_fsm: RTL and testbench

Multicycle sequencer for the MIPS datapath. It moves the design from single-cycle control to a shared instruction/data memory, with the ALU reused for PC increment and branch-target computation. A Moore state machine decodes `Op`/`Funct` and drives every mux select, write enable and ALU control line of the datapath across 3–5 cycles per instruction. Memory accesses stall on a ready handshake.

---
 rtl/multicycle_control_fsm.sv | 192 +++++++++++++++++++
 tb/tb_multicycle_control_fsm.sv | 232 +++++++++++++++++++++++
 2 files changed

// File: rtl/multicycle_control_fsm.sv
// ---------------------------------------------------------------------------
// multicycle_control_fsm
//   Moore control sequencer for a multicycle MIPS datapath with a shared
//   instruction/data memory. The ALU is reused for PC+4 and the branch target.
//   Memory states wait on MemReady.
//
// Ports
//   CLK          : clock, rising edge
//   reset        : asynchronous, active-low; returns to FETCH, clears IllegalInstr
//   Op, Funct    : opcode / funct fields of the instruction register
//   Zero         : ALU zero flag (qualifies the branch PC load)
//   MemReady     : memory completed the current request this cycle
//   MemReq       : memory request; MemWrite marks it as a write
//   IorD         : memory address select (0 = PC, 1 = ALUOut)
//   IRWrite      : instruction register load
//   PCEn         : PC load enable = PCWrite | (Branch & Zero)
//   PCSrc        : PC source (00 ALUResult, 01 ALUOut, 10 jump target)
//   ALUSrcA      : ALU A source (0 = PC, 1 = RD1)
//   ALUSrcB      : ALU B source (00 RD2, 01 4, 10 SignImm, 11 SignImm<<2)
//   ALUControl   : ALU operation
//   RegDst       : register write address (0 = rt, 1 = rd)
//   MemtoReg     : register write data (0 = ALUOut, 1 = data register)
//   RegWrite     : register file write enable
//   IllegalInstr : sticky flag for an undecodable opcode or funct
// ---------------------------------------------------------------------------
module multicycle_control_fsm (
  input  logic       CLK,
  input  logic       reset,
  input  logic [5:0] Op,
  input  logic [5:0] Funct,
  input  logic       Zero,
  input  logic       MemReady,
  output logic       MemReq,
  output logic       MemWrite,
  output logic       IorD,
  output logic       IRWrite,
  output logic       PCEn,
  output logic [1:0] PCSrc,
  output logic       ALUSrcA,
  output logic [1:0] ALUSrcB,
  output logic [2:0] ALUControl,
  output logic       RegDst,
  output logic       MemtoReg,
  output logic       RegWrite,
  output logic       IllegalInstr
);

  typedef enum logic [3:0] {
    FETCH, DECODE, MEMADR, MEMRD, MEMWB, MEMWR,
    EXECUTE, ALUWB, BRANCH, ADDIEXEC, ADDIWB, JUMP
  } state_t;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_J     = 6'b000010;

  localparam logic [2:0] ALU_ADD = 3'b010;
  localparam logic [2:0] ALU_SUB = 3'b110;
  localparam logic [2:0] ALU_AND = 3'b000;
  localparam logic [2:0] ALU_OR  = 3'b001;
  localparam logic [2:0] ALU_SLT = 3'b111;

  // Returns {funct_known, alu_op}; unknown functs fall back to add.
  function automatic logic [3:0] funct_decode(input logic [5:0] f);
    case (f)
      6'b100000: funct_decode = {1'b1, ALU_ADD};
      6'b100010: funct_decode = {1'b1, ALU_SUB};
      6'b100100: funct_decode = {1'b1, ALU_AND};
      6'b100101: funct_decode = {1'b1, ALU_OR};
      6'b101010: funct_decode = {1'b1, ALU_SLT};
      default:   funct_decode = {1'b0, ALU_ADD};
    endcase
  endfunction

  state_t     state;
  logic       funct_bad;   // remembers an unknown funct so ALUWB skips the write
  logic [3:0] fdec;
  logic       pc_write;
  logic       branch;

  assign fdec = funct_decode(Funct);

  always_ff @(posedge CLK or negedge reset) begin
    if (!reset) begin
      state        <= FETCH;
      IllegalInstr <= 1'b0;
      funct_bad    <= 1'b0;
    end else begin
      case (state)
        FETCH:    if (MemReady) state <= DECODE;
        DECODE: begin
          case (Op)
            OP_LW, OP_SW: state <= MEMADR;
            OP_RTYPE:     state <= EXECUTE;
            OP_BEQ:       state <= BRANCH;
            OP_ADDI:      state <= ADDIEXEC;
            OP_J:         state <= JUMP;
            default: begin
              state        <= FETCH;
              IllegalInstr <= 1'b1;
            end
          endcase
        end
        MEMADR:   state <= (Op == OP_SW) ? MEMWR : MEMRD;
        MEMRD:    if (MemReady) state <= MEMWB;
        MEMWR:    if (MemReady) state <= FETCH;
        EXECUTE: begin
          state     <= ALUWB;
          funct_bad <= ~fdec[3];
          if (!fdec[3]) IllegalInstr <= 1'b1;
        end
        ADDIEXEC: state <= ADDIWB;
        default:  state <= FETCH;
      endcase
    end
  end

  // Outputs are a pure decode of the current state; only IRWrite, PCEn and
  // ALUControl look at live inputs.
  always_comb begin
    MemReq     = 1'b0;
    MemWrite   = 1'b0;
    IorD       = 1'b0;
    IRWrite    = 1'b0;
    PCSrc      = 2'b00;
    ALUSrcA    = 1'b0;
    ALUSrcB    = 2'b00;
    ALUControl = 3'b000;
    RegDst     = 1'b0;
    MemtoReg   = 1'b0;
    RegWrite   = 1'b0;
    pc_write   = 1'b0;
    branch     = 1'b0;
    case (state)
      FETCH: begin
        MemReq     = 1'b1;
        ALUSrcB    = 2'b01;
        ALUControl = ALU_ADD;
        IRWrite    = MemReady;
        pc_write   = MemReady;
      end
      DECODE: begin
        ALUSrcB    = 2'b11;
        ALUControl = ALU_ADD;
      end
      MEMADR, ADDIEXEC: begin
        ALUSrcA    = 1'b1;
        ALUSrcB    = 2'b10;
        ALUControl = ALU_ADD;
      end
      MEMRD: begin
        MemReq = 1'b1;
        IorD   = 1'b1;
      end
      MEMWR: begin
        MemReq   = 1'b1;
        MemWrite = 1'b1;
        IorD     = 1'b1;
      end
      MEMWB: begin
        RegWrite = 1'b1;
        MemtoReg = 1'b1;
      end
      EXECUTE: begin
        ALUSrcA    = 1'b1;
        ALUControl = fdec[2:0];
      end
      ALUWB: begin
        RegDst   = 1'b1;
        RegWrite = ~funct_bad;
      end
      ADDIWB:   RegWrite = 1'b1;
      BRANCH: begin
        ALUSrcA    = 1'b1;
        ALUControl = ALU_SUB;
        PCSrc      = 2'b01;
        branch     = 1'b1;
      end
      JUMP: begin
        PCSrc    = 2'b10;
        pc_write = 1'b1;
      end
      default: ;
    endcase
  end

  assign PCEn = pc_write | (branch & Zero);

endmodule

// File: tb/tb_multicycle_control_fsm.sv
// ---------------------------------------------------------------------------
// tb_multicycle_control_fsm
//   Directed bench for multicycle_control_fsm. Each cycle the full output
//   word is compared against a hand-built expected word. Inputs are driven
//   and outputs sampled just after the falling edge.
//   Output word bit order (MSB first):
//   MemReq MemWrite IorD IRWrite PCEn PCSrc[1:0] ALUSrcA ALUSrcB[1:0]
//   ALUControl[2:0] RegDst MemtoReg RegWrite IllegalInstr
// ---------------------------------------------------------------------------
module tb_multicycle_control_fsm;

  logic       CLK = 1'b0;
  logic       reset;
  logic [5:0] Op;
  logic [5:0] Funct;
  logic       Zero;
  logic       MemReady;
  logic       MemReq, MemWrite, IorD, IRWrite, PCEn, ALUSrcA;
  logic [1:0] PCSrc, ALUSrcB;
  logic [2:0] ALUControl;
  logic       RegDst, MemtoReg, RegWrite, IllegalInstr;

  int n_checks = 0;
  int n_fail   = 0;

  multicycle_control_fsm dut (
    .CLK(CLK), .reset(reset), .Op(Op), .Funct(Funct), .Zero(Zero),
    .MemReady(MemReady), .MemReq(MemReq), .MemWrite(MemWrite), .IorD(IorD),
    .IRWrite(IRWrite), .PCEn(PCEn), .PCSrc(PCSrc), .ALUSrcA(ALUSrcA),
    .ALUSrcB(ALUSrcB), .ALUControl(ALUControl), .RegDst(RegDst),
    .MemtoReg(MemtoReg), .RegWrite(RegWrite), .IllegalInstr(IllegalInstr)
  );

  always #5 CLK = ~CLK;

  logic [16:0] obs;
  assign obs = {MemReq, MemWrite, IorD, IRWrite, PCEn, PCSrc, ALUSrcA, ALUSrcB,
                ALUControl, RegDst, MemtoReg, RegWrite, IllegalInstr};

  // Expected words per state (IllegalInstr clear).
  localparam logic [16:0] FR     = {1'b1,1'b0,1'b0,1'b1,1'b1,2'b00,1'b0,2'b01,3'b010,1'b0,1'b0,1'b0,1'b0};
  localparam logic [16:0] FW     = {1'b1,1'b0,1'b0,1'b0,1'b0,2'b00,1'b0,2'b01,3'b010,1'b0,1'b0,1'b0,1'b0};
  localparam logic [16:0] DEC    = {1'b0,1'b0,1'b0,1'b0,1'b0,2'b00,1'b0,2'b11,3'b010,1'b0,1'b0,1'b0,1'b0};
  localparam logic [16:0] MADR   = {1'b0,1'b0,1'b0,1'b0,1'b0,2'b00,1'b1,2'b10,3'b010,1'b0,1'b0,1'b0,1'b0};
  localparam logic [16:0] MRD    = {1'b1,1'b0,1'b1,1'b0,1'b0,2'b00,1'b0,2'b00,3'b000,1'b0,1'b0,1'b0,1'b0};
  localparam logic [16:0] MWB    = {1'b0,1'b0,1'b0,1'b0,1'b0,2'b00,1'b0,2'b00,3'b000,1'b0,1'b1,1'b1,1'b0};
  localparam logic [16:0] MWR    = {1'b1,1'b1,1'b1,1'b0,1'b0,2'b00,1'b0,2'b00,3'b000,1'b0,1'b0,1'b0,1'b0};
  localparam logic [16:0] AWB    = {1'b0,1'b0,1'b0,1'b0,1'b0,2'b00,1'b0,2'b00,3'b000,1'b1,1'b0,1'b1,1'b0};
  localparam logic [16:0] AWB_NW = {1'b0,1'b0,1'b0,1'b0,1'b0,2'b00,1'b0,2'b00,3'b000,1'b1,1'b0,1'b0,1'b0};
  localparam logic [16:0] IWB    = {1'b0,1'b0,1'b0,1'b0,1'b0,2'b00,1'b0,2'b00,3'b000,1'b0,1'b0,1'b1,1'b0};
  localparam logic [16:0] BR_Z   = {1'b0,1'b0,1'b0,1'b0,1'b1,2'b01,1'b1,2'b00,3'b110,1'b0,1'b0,1'b0,1'b0};
  localparam logic [16:0] BR_NZ  = {1'b0,1'b0,1'b0,1'b0,1'b0,2'b01,1'b1,2'b00,3'b110,1'b0,1'b0,1'b0,1'b0};
  localparam logic [16:0] JMP    = {1'b0,1'b0,1'b0,1'b0,1'b1,2'b10,1'b0,2'b00,3'b000,1'b0,1'b0,1'b0,1'b0};
  localparam logic [16:0] EX_ADD = {1'b0,1'b0,1'b0,1'b0,1'b0,2'b00,1'b1,2'b00,3'b010,1'b0,1'b0,1'b0,1'b0};
  localparam logic [16:0] EX_SUB = {1'b0,1'b0,1'b0,1'b0,1'b0,2'b00,1'b1,2'b00,3'b110,1'b0,1'b0,1'b0,1'b0};
  localparam logic [16:0] ILL    = 17'h00001;

  task automatic test_reset();
    reset = 1'b0; MemReady = 1'b0; Op = 6'd0; Funct = 6'd0; Zero = 1'b0;
    #3;
    n_checks++;
    if (obs !== FW) begin
      n_fail++;
      $display("FAIL reset_state: got %b expected %b", obs, FW);
    end
    @(negedge CLK); reset = 1'b1; #1;
    n_checks++;
    if (obs !== FW) begin
      n_fail++;
      $display("FAIL reset_release: got %b expected %b", obs, FW);
    end
  endtask

  task automatic test_lw();
    logic [16:0] ev [6] = '{FR, DEC, MADR, MRD, MWB, FW};
    logic        mr [6] = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0};
    Op = 6'b100011;
    for (int i = 0; i < 6; i++) begin
      @(negedge CLK); MemReady = mr[i]; #1;
      n_checks++;
      if (obs !== ev[i]) begin
        n_fail++;
        $display("FAIL lw cycle %0d: got %b expected %b", i, obs, ev[i]);
      end
    end
  endtask

  task automatic test_rtype_sub_stall();
    logic [16:0] ev [7] = '{FW, FW, FR, DEC, EX_SUB, AWB, FW};
    logic        mr [7] = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0};
    Op = 6'b000000; Funct = 6'b100010;
    for (int i = 0; i < 7; i++) begin
      @(negedge CLK); MemReady = mr[i]; #1;
      n_checks++;
      if (obs !== ev[i]) begin
        n_fail++;
        $display("FAIL rtype_sub cycle %0d: got %b expected %b", i, obs, ev[i]);
      end
    end
  endtask

  task automatic test_beq();
    logic [16:0] ev [8] = '{FR, DEC, BR_Z, FW, FR, DEC, BR_NZ, FW};
    logic        mr [8] = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0};
    Op = 6'b000100;
    for (int i = 0; i < 8; i++) begin
      @(negedge CLK); MemReady = mr[i]; Zero = (i < 4); #1;
      n_checks++;
      if (obs !== ev[i]) begin
        n_fail++;
        $display("FAIL beq cycle %0d zero %0d: got %b expected %b", i, Zero, obs, ev[i]);
      end
    end
    Zero = 1'b0;
  endtask

  task automatic test_sw_stall();
    logic [16:0] ev [8] = '{FR, DEC, MADR, MWR, MWR, MWR, MWR, FW};
    logic        mr [8] = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0};
    Op = 6'b101011;
    for (int i = 0; i < 8; i++) begin
      @(negedge CLK); MemReady = mr[i]; #1;
      n_checks++;
      if (obs !== ev[i]) begin
        n_fail++;
        $display("FAIL sw cycle %0d: got %b expected %b", i, obs, ev[i]);
      end
    end
  endtask

  task automatic test_jump();
    logic [16:0] ev [4] = '{FR, DEC, JMP, FW};
    logic        mr [4] = '{1'b1, 1'b1, 1'b1, 1'b0};
    Op = 6'b000010;
    for (int i = 0; i < 4; i++) begin
      @(negedge CLK); MemReady = mr[i]; #1;
      n_checks++;
      if (obs !== ev[i]) begin
        n_fail++;
        $display("FAIL jump cycle %0d: got %b expected %b", i, obs, ev[i]);
      end
    end
  endtask

  // Illegal opcode, then an addi with the sticky flag still set, then reset.
  task automatic test_illegal_opcode();
    logic [16:0] ev [9] = '{FR, DEC, FW | ILL, FR | ILL, DEC | ILL, MADR | ILL,
                            IWB | ILL, FW | ILL, FW | ILL};
    logic        mr [9] = '{1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0};
    for (int i = 0; i < 9; i++) begin
      @(negedge CLK);
      Op = (i < 3) ? 6'b111111 : 6'b001000;
      MemReady = mr[i]; #1;
      n_checks++;
      if (obs !== ev[i]) begin
        n_fail++;
        $display("FAIL illegal_op cycle %0d: got %b expected %b", i, obs, ev[i]);
      end
    end
    #2 reset = 1'b0; #1;
    n_checks++;
    if (obs !== FW) begin
      n_fail++;
      $display("FAIL illegal_clear: got %b expected %b", obs, FW);
    end
    @(negedge CLK); reset = 1'b1;
  endtask

  // Unknown funct: add in EXECUTE, no register write in ALUWB, flag set.
  task automatic test_illegal_funct();
    logic [16:0] ev [5] = '{FR, DEC, EX_ADD, AWB_NW | ILL, FW | ILL};
    logic        mr [5] = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b0};
    Op = 6'b000000; Funct = 6'b111111;
    for (int i = 0; i < 5; i++) begin
      @(negedge CLK); MemReady = mr[i]; #1;
      n_checks++;
      if (obs !== ev[i]) begin
        n_fail++;
        $display("FAIL illegal_funct cycle %0d: got %b expected %b", i, obs, ev[i]);
      end
    end
    #2 reset = 1'b0; #1;
    n_checks++;
    if (obs !== FW) begin
      n_fail++;
      $display("FAIL illegal_funct_clear: got %b expected %b", obs, FW);
    end
    @(negedge CLK); reset = 1'b1;
  endtask

  // Reset pulled low in ALUWB must drop RegWrite immediately.
  task automatic test_reset_mid_instr();
    logic [16:0] ev [4] = '{FR, DEC, EX_ADD, AWB};
    logic        mr [4] = '{1'b1, 1'b1, 1'b1, 1'b0};
    Op = 6'b000000; Funct = 6'b100000;
    for (int i = 0; i < 4; i++) begin
      @(negedge CLK); MemReady = mr[i]; #1;
      n_checks++;
      if (obs !== ev[i]) begin
        n_fail++;
        $display("FAIL reset_mid cycle %0d: got %b expected %b", i, obs, ev[i]);
      end
    end
    #2 reset = 1'b0; #1;
    n_checks++;
    if (obs !== FW) begin
      n_fail++;
      $display("FAIL reset_mid_async: got %b expected %b", obs, FW);
    end
    @(negedge CLK); reset = 1'b1; #1;
    n_checks++;
    if (obs !== FW) begin
      n_fail++;
      $display("FAIL reset_mid_after: got %b expected %b", obs, FW);
    end
  endtask

  initial begin
    test_reset();
    test_lw();
    test_rtype_sub_stall();
    test_beq();
    test_sw_stall();
    test_jump();
    test_illegal_opcode();
    test_illegal_funct();
    test_reset_mid_instr();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
